updn_button_ctrl: RTL

Front-end command stage for the 5-bit up/down counter. It turns three raw, asynchronous push-buttons and a 5-bit switch bank into clean single-cycle `load`, `up` and `down` command pulses plus a held `load_val` word, so they can drive the counter directly. It synchronises, debounces and edge-detects each button, resolves conflicting commands, and optionally auto-repeats held buttons. It also consumes the counter's `h_flag`/`l_flag` to report requests that would be dropped at a limit.

---
 rtl/updn_pkg.sv | 22 ++
 rtl/btn_debounce.sv | 49 ++++
 rtl/updn_button_ctrl.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/updn_pkg.sv
// Shared state type and sizing helpers for the up/down counter button front end.
package updn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FIRST,
        ST_HOLD,
        ST_REPEAT
    } req_state_t;

    localparam int CNT_W_DEF = 5;
    localparam int NUM_BTN   = 3;
    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LOAD  = 2;

    // Bits needed for a counter running 0 .. max_count-1.
    function automatic int ctr_width(input int max_count);
        return (max_count < 2) ? 1 : $clog2(max_count);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus debouncer for one raw button; rise/fall are
// combinational strobes valid in the cycle the debounced level flips.
module btn_debounce
    import updn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic rise,
    output logic fall
);

    localparam int CW = ctr_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_reg;
    logic          sync2_reg;
    logic          level_reg;
    logic [CW-1:0] cnt_reg;
    logic          flip;

    // The level flips on the DEBOUNCE_CYCLES-th consecutive disagreeing sample.
    assign flip = (sync2_reg != level_reg) && (cnt_reg == LAST);
    assign rise = flip && !level_reg;
    assign fall = flip && level_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            level_reg <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            sync1_reg <= btn;
            sync2_reg <= sync1_reg;
            if (sync2_reg == level_reg) begin
                cnt_reg <= '0;
            end else if (flip) begin
                level_reg <= sync2_reg;
                cnt_reg   <= '0;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/updn_button_ctrl.sv
// Button front end: debounced per-button request FSMs, command arbitration and
// load value capture. Define UPDN_AUTOREPEAT_EN to auto-repeat held up/down.
module updn_button_ctrl
    import updn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 8,
    parameter int REPEAT_PERIOD   = 3,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic             btn_load,
    input  logic [CNT_W-1:0] sw_in,
    input  logic             h_flag,
    input  logic             l_flag,
    output logic             up,
    output logic             down,
    output logic             load,
    output logic [CNT_W-1:0] load_val,
    output logic             blocked
);

`ifdef UPDN_AUTOREPEAT_EN
    localparam bit REPEAT_EN = 1'b1;
`else
    localparam bit REPEAT_EN = 1'b0;
`endif

    if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 2) begin : g_bad_params
        $error("updn_button_ctrl: illegal DEBOUNCE_CYCLES/REPEAT_DELAY/REPEAT_PERIOD");
    end

    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] rise;
    logic [NUM_BTN-1:0] fall;
    logic [NUM_BTN-1:0] req;

    assign btn_raw = {btn_load, btn_down, btn_up};

    genvar gi;
    for (gi = 0; gi < NUM_BTN; gi++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk  (clk),
            .rst  (rst),
            .btn  (btn_raw[gi]),
            .rise (rise[gi]),
            .fall (fall[gi])
        );

        if (REPEAT_EN && gi != BTN_LOAD) begin : g_rep
            localparam int RW = ctr_width((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);
            localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
            localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

            req_state_t    state_reg, state_next;
            logic [RW-1:0] rep_cnt_reg, rep_cnt_next;
            logic          req_bit;

            always_ff @(posedge clk) begin
                if (rst) begin
                    state_reg   <= ST_IDLE;
                    rep_cnt_reg <= '0;
                end else begin
                    state_reg   <= state_next;
                    rep_cnt_reg <= rep_cnt_next;
                end
            end

            always_comb begin
                state_next   = state_reg;
                rep_cnt_next = '0;
                req_bit      = 1'b0;
                case (state_reg)
                    ST_IDLE:   if (rise[gi]) state_next = ST_FIRST;
                    ST_FIRST: begin
                        req_bit    = 1'b1;
                        state_next = ST_HOLD;
                    end
                    ST_HOLD: begin
                        if (rep_cnt_reg == DELAY_LAST) begin
                            req_bit    = 1'b1;
                            state_next = ST_REPEAT;
                        end else begin
                            rep_cnt_next = rep_cnt_reg + 1'b1;
                        end
                    end
                    ST_REPEAT: begin
                        if (rep_cnt_reg == PERIOD_LAST) req_bit = 1'b1;
                        else                            rep_cnt_next = rep_cnt_reg + 1'b1;
                    end
                    default:   state_next = ST_IDLE;
                endcase
                // Release wins over any request due in the same cycle.
                if (fall[gi]) begin
                    state_next   = ST_IDLE;
                    rep_cnt_next = '0;
                    req_bit      = 1'b0;
                end
            end

            assign req[gi] = req_bit;
        end else begin : g_once
            req_state_t state_reg, state_next;
            logic       req_bit;

            always_ff @(posedge clk) begin
                if (rst) state_reg <= ST_IDLE;
                else     state_reg <= state_next;
            end

            always_comb begin
                state_next = state_reg;
                req_bit    = 1'b0;
                case (state_reg)
                    ST_IDLE:  if (rise[gi]) state_next = ST_FIRST;
                    ST_FIRST: begin
                        req_bit    = 1'b1;
                        state_next = ST_HOLD;
                    end
                    default:  ;  // HOLD waits for release
                endcase
                if (fall[gi]) begin
                    state_next = ST_IDLE;
                    req_bit    = 1'b0;
                end
            end

            assign req[gi] = req_bit;
        end
    end

    logic [CNT_W-1:0] sw_sync1_reg, sw_sync2_reg, load_val_reg;
    logic             up_reg, down_reg, load_reg, blocked_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sw_sync1_reg <= '0;
            sw_sync2_reg <= '0;
            load_val_reg <= '0;
            up_reg       <= 1'b0;
            down_reg     <= 1'b0;
            load_reg     <= 1'b0;
            blocked_reg  <= 1'b0;
        end else begin
            sw_sync1_reg <= sw_in;
            sw_sync2_reg <= sw_sync1_reg;
            up_reg       <= 1'b0;
            down_reg     <= 1'b0;
            load_reg     <= 1'b0;
            blocked_reg  <= 1'b0;
            // Load has priority; simultaneous up and down cancel silently.
            if (req[BTN_LOAD]) begin
                load_reg     <= 1'b1;
                load_val_reg <= sw_sync2_reg;
            end else if (req[BTN_UP] && !req[BTN_DOWN]) begin
                up_reg      <= 1'b1;
                blocked_reg <= h_flag;
            end else if (req[BTN_DOWN] && !req[BTN_UP]) begin
                down_reg    <= 1'b1;
                blocked_reg <= l_flag;
            end
        end
    end

    assign up       = up_reg;
    assign down     = down_reg;
    assign load     = load_reg;
    assign blocked  = blocked_reg;
    assign load_val = load_val_reg;

endmodule
